sobel_stream_filter: RTL and testbench

SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

---
 rtl/sobel_stream_filter.sv | 168 ++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter over a raster-order frame.
// Two line buffers feed a sliding window, and one registered result is produced per full window.
module sobel_stream_filter #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [OUT_W-1:0] thresh,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [OUT_W-1:0] conv_result,
    output logic             conv_valid,
    output logic             enable,
    output logic             end_sign
);
    localparam int unsigned CB = $clog2(IMG_W);
    localparam int unsigned RB = $clog2(IMG_H);
    localparam int unsigned GW = PIX_W + 4;
    localparam int unsigned MW = (OUT_W > GW) ? OUT_W + 1 : GW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [OUT_W-1:0] thresh_q;
    logic [CB-1:0]    col;
    logic [RB-1:0]    row;

    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [PIX_W-1:0] lb_mid [IMG_W];
    // The two older window columns are registered; the newest column is
    // formed from the line buffers and the incoming pixel, so the result is
    // ready on the accepting edge.
    logic [PIX_W-1:0] win [3][2];
    logic [PIX_W-1:0] new_col [3];

    logic                accept;
    logic                last_col;
    logic                last_pix;
    logic                full_win;
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [GW-1:0]       ax;
    logic [GW-1:0]       ay;
    logic [MW-1:0]       mag;
    logic [MW-1:0]       sel;
    logic [MW-1:0]       sat_max;
    logic [OUT_W-1:0]    res;

    function automatic logic signed [GW-1:0] sx(input logic [PIX_W-1:0] p);
        return signed'(GW'(p));
    endfunction

    assign accept   = pix_valid && pix_ready;
    assign last_col = (col == CB'(IMG_W - 1));
    assign last_pix = last_col && (row == RB'(IMG_H - 1));
    assign full_win = (row >= RB'(2)) && (col >= CB'(2));

    always_comb begin
        new_col[0] = lb_top[col];
        new_col[1] = lb_mid[col];
        new_col[2] = pix_in;

        gx = (sx(new_col[0]) - sx(win[0][0]))
           + ((sx(new_col[1]) - sx(win[1][0])) <<< 1)
           + (sx(new_col[2]) - sx(win[2][0]));
        gy = (sx(win[2][0]) + (sx(win[2][1]) <<< 1) + sx(new_col[2]))
           - (sx(win[0][0]) + (sx(win[0][1]) <<< 1) + sx(new_col[0]));

        ax  = gx[GW-1] ? unsigned'(-gx) : unsigned'(gx);
        ay  = gy[GW-1] ? unsigned'(-gy) : unsigned'(gy);
        mag = MW'(ax) + MW'(ay);

        sat_max = '0;
        sat_max[OUT_W-1:0] = '1;

        case (mode_q)
            2'd1:    sel = MW'(ax);
            2'd2:    sel = MW'(ay);
            default: sel = mag;
        endcase

        res = '0;
        if (mode_q == 2'd3) begin
            res[0] = (mag >= MW'(thresh_q));
        end else if (sel > sat_max) begin
            res = sat_max[OUT_W-1:0];
        end else begin
            res = sel[OUT_W-1:0];
        end
    end

    // Line-buffer RAM: no reset, every location is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= '0;
            thresh_q    <= '0;
            col         <= '0;
            row         <= '0;
            conv_result <= '0;
            conv_valid  <= 1'b0;
            pix_ready   <= 1'b0;
            enable      <= 1'b0;
            end_sign    <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 2; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            conv_valid <= 1'b0;
            end_sign   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        mode_q    <= mode;
                        thresh_q  <= thresh;
                        pix_ready <= 1'b1;
                        enable    <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        for (int unsigned r = 0; r < 3; r++) begin
                            win[r][0] <= win[r][1];
                            win[r][1] <= new_col[r];
                        end
                        if (last_col) begin
                            col <= '0;
                            row <= last_pix ? '0 : row + RB'(1);
                        end else begin
                            col <= col + CB'(1);
                        end
                        if (full_win) begin
                            conv_valid  <= 1'b1;
                            conv_result <= res;
                        end
                        if (last_pix) begin
                            state     <= DONE;
                            pix_ready <= 1'b0;
                            end_sign  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter: table of frame/mode vectors plus
// hand-written sequences for saturation, mid-frame reset and ignored start.
module tb_sobel_stream_filter;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 8;
    localparam int unsigned OUT_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = '0;
    logic [OUT_W-1:0] thresh = '0;
    logic [PIX_W-1:0] pix_in = '0;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [OUT_W-1:0] conv_result;
    logic             conv_valid;
    logic             enable;
    logic             end_sign;

    sobel_stream_filter #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .thresh(thresh),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .conv_result(conv_result),
        .conv_valid(conv_valid),
        .enable(enable),
        .end_sign(end_sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                kind;
        int                m;
        int                th;
        bit                gaps;
        logic [5:0][15:0]  erow;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int res [64];
    int nres;
    int nend;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 0: constant 100, 1: columns 4..7 = 255, 2: quadrant rows/cols >= 4 = 255
    function automatic logic [7:0] pix_at(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c >= 4) ? 8'd255 : 8'd0;
            default: return (r >= 4 && c >= 4) ? 8'd255 : 8'd0;
        endcase
    endfunction

    function automatic vec_t mk(input int kind, input int m, input int th, input bit gaps,
                                input int e2, input int e3, input int e4,
                                input int e5, input int e6, input int e7);
        vec_t v;
        v.kind = kind; v.m = m; v.th = th; v.gaps = gaps;
        v.erow[0] = 16'(e2); v.erow[1] = 16'(e3); v.erow[2] = 16'(e4);
        v.erow[3] = 16'(e5); v.erow[4] = 16'(e6); v.erow[5] = 16'(e7);
        return v;
    endfunction

    task automatic run_frame(input int kind, input int m, input int th, input bit gaps, input bit poke);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        bit  exp_v;
        int  r;
        int  c;
        nres = 0;
        nend = 0;
        @(negedge clk);
        start = 1'b1; mode = 2'(m); thresh = OUT_W'(th);
        pix_valid = 1'b1; pix_in = 8'hFF;
        check("idle_ready", int'(pix_ready), 0);
        @(negedge clk);
        start = 1'b0; mode = 2'(m) ^ 2'd1; thresh = '0;
        while (idx < IMG_W * IMG_H && cyc < 2000) begin
            r = idx / IMG_W;
            c = idx % IMG_W;
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_in = pix_valid ? pix_at(kind, r, c) : 8'($urandom);
            start = poke && (idx == 30);
            acc = pix_valid && pix_ready;
            exp_v = acc && r >= 2 && c >= 2;
            @(negedge clk);
            cyc++;
            check("conv_valid_timing", int'(conv_valid), int'(exp_v));
            if (conv_valid && nres < 64) begin
                res[nres] = int'(conv_result);
                nres++;
            end
            if (end_sign) nend++;
            if (acc) idx++;
        end
        if (idx < IMG_W * IMG_H) check("frame_timeout", idx, IMG_W * IMG_H);
        check("done_end_sign", int'(end_sign), 1);
        check("done_enable", int'(enable), 1);
        pix_valid = 1'b0;
        start = poke;
        @(negedge clk);
        start = 1'b0;
        check("idle_enable", int'(enable), 0);
        check("idle_end_sign", int'(end_sign), 0);
        check("end_sign_count", nend, 1);
        check("result_count", nres, (IMG_W - 2) * (IMG_H - 2));
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = mk(0, 0, 0,    0, 0, 0, 0,    0,    0, 0);
        vecs[1] = mk(1, 1, 0,    0, 0, 0, 1020, 1020, 0, 0);
        vecs[2] = mk(1, 2, 0,    0, 0, 0, 0,    0,    0, 0);
        vecs[3] = mk(1, 0, 0,    0, 0, 0, 1020, 1020, 0, 0);
        vecs[4] = mk(1, 3, 500,  0, 0, 0, 1,    1,    0, 0);
        vecs[5] = mk(1, 3, 1021, 0, 0, 0, 0,    0,    0, 0);
        vecs[6] = mk(1, 3, 1020, 0, 0, 0, 1,    1,    0, 0);
        vecs[7] = mk(1, 1, 0,    1, 0, 0, 1020, 1020, 0, 0);
        vecs[8] = mk(0, 3, 0,    0, 1, 1, 1,    1,    1, 1);

        repeat (3) @(negedge clk);
        check("rst_conv_result", int'(conv_result), 0);
        check("rst_conv_valid", int'(conv_valid), 0);
        check("rst_pix_ready", int'(pix_ready), 0);
        check("rst_enable", int'(enable), 0);
        check("rst_end_sign", int'(end_sign), 0);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].kind, vecs[v].m, vecs[v].th, vecs[v].gaps, 1'b0);
            for (int i = 0; i < nres && i < 36; i++) begin
                check($sformatf("vec%0d_res%0d", v, i), res[i], int'(vecs[v].erow[i % 6]));
            end
        end

        // Quadrant frame: (4,4) -> 255+255, (5,5) -> 765+765 saturates at 10 bits.
        run_frame(2, 0, 0, 1'b0, 1'b0);
        check("quad_m0_r4c4", res[14], 510);
        check("quad_m0_r5c5_sat", res[21], 1023);
        check("quad_m0_r2c2", res[0], 0);
        run_frame(2, 1, 0, 1'b0, 1'b0);
        check("quad_m1_r5c5", res[21], 765);

        // Start pulsed mid-frame and in the DONE cycle must be ignored.
        run_frame(0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("poke_no_restart", int'(enable), 0);

        // Mid-frame reset after 22 pixels of the step frame.
        @(negedge clk);
        start = 1'b1; mode = 2'd1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 22; k++) begin
            pix_valid = 1'b1;
            pix_in = pix_at(1, k / IMG_W, k % IMG_W);
            @(negedge clk);
        end
        check("partial_valid", int'(conv_valid), 1);
        check("partial_result", int'(conv_result), 1020);
        pix_valid = 1'b0;
        @(negedge clk);
        check("hold_valid", int'(conv_valid), 0);
        check("hold_result", int'(conv_result), 1020);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_conv_result", int'(conv_result), 0);
        check("midrst_conv_valid", int'(conv_valid), 0);
        check("midrst_pix_ready", int'(pix_ready), 0);
        check("midrst_enable", int'(enable), 0);
        check("midrst_end_sign", int'(end_sign), 0);
        rst = 1'b0;
        run_frame(0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < nres && i < 36; i++) begin
            check($sformatf("after_rst_res%0d", i), res[i], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
